// File: rtl/rot_arbiter.sv
// Round-robin arbiter for two requesters sharing a 16-bit register.
// Each granted command is a byte load or a bit-serial rotate-right; completion is a tagged done pulse.
module rot_arbiter #(
    parameter  int unsigned CW = 4,
    localparam int unsigned W  = 16
) (
    input  logic          clk,
    input  logic          R,
    input  logic          req0,
    input  logic          req1,
    input  logic          cmd0,
    input  logic          cmd1,
    input  logic [CW-1:0] amt0,
    input  logic [CW-1:0] amt1,
    input  logic [7:0]    d0,
    input  logic [7:0]    d1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          busy,
    output logic          done,
    output logic          done_id,
    output logic [W-1:0]  Q
);

    localparam int unsigned DW = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_ROT  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [CW-1:0]   cnt;
    logic [DW-1:0]   data_cap;
    logic            cur_id;
    logic            last;

    logic            any_req;
    logic            gid;
    logic            sel_cmd;
    logic [CW-1:0]   sel_amt;
    logic [DW-1:0]   sel_d;

    logic [W-1:0]    q_next;
    logic [CW-1:0]   cnt_next;
    logic [DW-1:0]   data_next;
    logic            cur_id_next;
    logic            last_next;
    logic            gnt0_next;
    logic            gnt1_next;
    logic            busy_next;
    logic            done_next;
    logic            done_id_next;

    // Round-robin pick: on a tie the requester not served last wins.
    always_comb begin
        any_req = req0 | req1;
        gid     = (req0 & req1) ? ~last : req1;
        sel_cmd = gid ? cmd1 : cmd0;
        sel_amt = gid ? amt1 : amt0;
        sel_d   = gid ? d1   : d0;
    end

    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (any_req) begin
                    state_next = sel_cmd ? S_ROT : S_LOAD;
                end
            end
            S_LOAD:  state_next = S_DONE;
            S_ROT: begin
                if (cnt == '0) begin
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Next values for the datapath and the registered outputs.
    always_comb begin
        q_next       = Q;
        cnt_next     = cnt;
        data_next    = data_cap;
        cur_id_next  = cur_id;
        last_next    = last;
        gnt0_next    = 1'b0;
        gnt1_next    = 1'b0;
        busy_next    = (state_next != S_IDLE);
        done_next    = (state_next == S_DONE);
        done_id_next = (state_next == S_DONE) ? cur_id : 1'b0;
        case (state)
            S_IDLE: begin
                if (any_req) begin
                    cur_id_next = gid;
                    data_next   = sel_d;
                    cnt_next    = sel_amt;
                    last_next   = gid;
                    gnt0_next   = ~gid;
                    gnt1_next   = gid;
                end
            end
            S_LOAD: begin
                q_next = {Q[W-1:DW], data_cap};
            end
            S_ROT: begin
                if (cnt != '0) begin
                    q_next   = {Q[0], Q[W-1:1]};
                    cnt_next = cnt - CW'(1);
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            Q        <= '0;
            cnt      <= '0;
            data_cap <= '0;
            cur_id   <= 1'b0;
            last     <= 1'b1;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            done_id  <= 1'b0;
        end else begin
            Q        <= q_next;
            cnt      <= cnt_next;
            data_cap <= data_next;
            cur_id   <= cur_id_next;
            last     <= last_next;
            gnt0     <= gnt0_next;
            gnt1     <= gnt1_next;
            busy     <= busy_next;
            done     <= done_next;
            done_id  <= done_id_next;
        end
    end

    // Grants are one-hot and never overlap a done pulse.
    always_ff @(posedge clk) begin
        if (R) begin
            assert (!(gnt0 && gnt1));
            assert (!(done && (gnt0 || gnt1)));
        end
    end

endmodule

// File: tb/tb_rot_arbiter.sv
// Directed self-checking bench for rot_arbiter: loads, rotates, round-robin ties and mid-command reset.
module tb_rot_arbiter;

    logic        clk;
    logic        R;
    logic        req0, req1, cmd0, cmd1;
    logic [3:0]  amt0, amt1;
    logic [7:0]  d0, d1;
    logic        gnt0, gnt1, busy, done, done_id;
    logic [15:0] Q;

    int total;
    int bad;

    rot_arbiter dut (
        .clk     (clk),
        .R       (R),
        .req0    (req0),
        .req1    (req1),
        .cmd0    (cmd0),
        .cmd1    (cmd1),
        .amt0    (amt0),
        .amt1    (amt1),
        .d0      (d0),
        .d1      (d1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .Q       (Q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        R = 1'b0;
        tick();
        tick();
        R = 1'b1;
        tick();
    endtask

    // Issue one command, drop req (and scramble operands) in the gnt cycle, wait for done, then one more cycle to IDLE.
    task automatic run_cmd(input logic id, input logic c, input logic [3:0] a, input logic [7:0] dv,
                           output int gcyc, output int dcyc, output logic did, output int bcyc);
        gcyc = -1;
        dcyc = -1;
        did  = 1'b0;
        bcyc = 0;
        if (!id) begin
            req0 = 1'b1; cmd0 = c; amt0 = a; d0 = dv;
        end else begin
            req1 = 1'b1; cmd1 = c; amt1 = a; d1 = dv;
        end
        for (int i = 1; i <= 20; i++) begin
            tick();
            if ((id ? gnt1 : gnt0) === 1'b1) begin
                gcyc = i;
                break;
            end
        end
        req0 = 1'b0; cmd0 = ~c; amt0 = ~a; d0 = ~dv;
        req1 = 1'b0; cmd1 = ~c; amt1 = ~a; d1 = ~dv;
        if (gcyc > 0) begin
            if (busy === 1'b1) bcyc++;
            for (int k = 1; k <= 40; k++) begin
                tick();
                if (busy === 1'b1) bcyc++;
                if (done === 1'b1) begin
                    dcyc = k;
                    did  = done_id;
                    break;
                end
            end
            tick();
            if (busy === 1'b1) bcyc++;
        end
    endtask

    // Both requesters raise req together and each holds it until its own gnt; records event order.
    // Event codes: 0 = gnt0, 1 = gnt1, 2 = done id0, 3 = done id1.
    task automatic run_tie(output int n, output int e0, output int e1, output int e2, output int e3,
                           output int viol);
        int ev[0:7];
        n = 0;
        viol = 0;
        for (int j = 0; j < 8; j++) ev[j] = -1;
        req0 = 1'b1; cmd0 = 1'b0; d0 = 8'h11; amt0 = 4'd0;
        req1 = 1'b1; cmd1 = 1'b0; d1 = 8'h22; amt1 = 4'd0;
        for (int i = 0; i < 30 && n < 4; i++) begin
            tick();
            if (gnt0 && gnt1) viol++;
            if (done && (gnt0 || gnt1)) viol++;
            if (gnt0 === 1'b1 && n < 8) begin ev[n] = 0; n++; req0 = 1'b0; end
            if (gnt1 === 1'b1 && n < 8) begin ev[n] = 1; n++; req1 = 1'b0; end
            if (done === 1'b1 && n < 8) begin ev[n] = done_id ? 3 : 2; n++; end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        e0 = ev[0]; e1 = ev[1]; e2 = ev[2]; e3 = ev[3];
    endtask

    task automatic test_reset();
        R = 1'b0;
        tick();
        total++;
        if ({Q, gnt0, gnt1, busy, done, done_id} !== 21'h0) begin
            bad++;
            $display("FAIL reset_state: got Q=%h gnt=%b%b busy=%b done=%b id=%b, want all zero",
                     Q, gnt0, gnt1, busy, done, done_id);
        end
        R = 1'b1;
        tick();
    endtask

    task automatic test_load();
        int g, dc, b;
        logic di;
        run_cmd(1'b0, 1'b0, 4'd0, 8'hA5, g, dc, di, b);
        total++;
        if (Q !== 16'h00A5) begin bad++; $display("FAIL load_a5_q: got %h want 00a5", Q); end
        total++;
        if (g !== 1) begin bad++; $display("FAIL load_gnt_latency: got %0d want 1", g); end
        total++;
        if (dc !== 1 || di !== 1'b0) begin
            bad++; $display("FAIL load_done: got cyc=%0d id=%b want cyc=1 id=0", dc, di);
        end
        total++;
        if (b !== 2) begin bad++; $display("FAIL load_busy: got %0d want 2", b); end
    endtask

    task automatic test_upper_byte();
        int g, dc, b;
        logic di;
        do_reset();
        run_cmd(1'b0, 1'b0, 4'd0, 8'h12, g, dc, di, b);
        run_cmd(1'b0, 1'b1, 4'd8, 8'h00, g, dc, di, b);
        total++;
        if (Q !== 16'h1200) begin bad++; $display("FAIL rot8_q: got %h want 1200", Q); end
        run_cmd(1'b1, 1'b0, 4'd0, 8'h34, g, dc, di, b);
        total++;
        if (Q !== 16'h1234) begin bad++; $display("FAIL load_34_q: got %h want 1234", Q); end
        run_cmd(1'b1, 1'b0, 4'd0, 8'hFF, g, dc, di, b);
        total++;
        if (Q !== 16'h12FF) begin bad++; $display("FAIL load_ff_q: got %h want 12ff", Q); end
        total++;
        if (dc !== 1 || di !== 1'b1) begin
            bad++; $display("FAIL load1_done: got cyc=%0d id=%b want cyc=1 id=1", dc, di);
        end
    endtask

    task automatic test_rotate();
        int g, dc, b;
        logic di;
        do_reset();
        run_cmd(1'b0, 1'b0, 4'd0, 8'h01, g, dc, di, b);
        run_cmd(1'b0, 1'b1, 4'd1, 8'h00, g, dc, di, b);
        total++;
        if (Q !== 16'h8000) begin bad++; $display("FAIL rot1_q: got %h want 8000", Q); end
        total++;
        if (dc !== 2) begin bad++; $display("FAIL rot1_done: got %0d want 2", dc); end
        do_reset();
        run_cmd(1'b0, 1'b0, 4'd0, 8'h01, g, dc, di, b);
        run_cmd(1'b0, 1'b1, 4'd15, 8'h00, g, dc, di, b);
        total++;
        if (Q !== 16'h0002) begin bad++; $display("FAIL rot15_q: got %h want 0002", Q); end
        total++;
        if (dc !== 16 || di !== 1'b0) begin
            bad++; $display("FAIL rot15_done: got cyc=%0d id=%b want cyc=16 id=0", dc, di);
        end
    endtask

    task automatic test_rot_zero();
        int g, dc, b;
        logic di;
        run_cmd(1'b1, 1'b1, 4'd0, 8'h00, g, dc, di, b);
        total++;
        if (Q !== 16'h0002) begin bad++; $display("FAIL rot0_q: got %h want 0002", Q); end
        total++;
        if (dc !== 1 || di !== 1'b1) begin
            bad++; $display("FAIL rot0_done: got cyc=%0d id=%b want cyc=1 id=1", dc, di);
        end
        total++;
        if (b !== 2) begin bad++; $display("FAIL rot0_busy: got %0d want 2", b); end
    endtask

    task automatic test_back_to_back();
        int n, e0, e1, e2, e3, v;
        do_reset();
        run_tie(n, e0, e1, e2, e3, v);
        total++;
        if (n !== 4 || e0 !== 0 || e1 !== 2 || e2 !== 1 || e3 !== 3) begin
            bad++; $display("FAIL tie_order: got n=%0d %0d %0d %0d %0d want n=4 0 2 1 3", n, e0, e1, e2, e3);
        end
        total++;
        if (v !== 0) begin bad++; $display("FAIL tie_overlap: got %0d want 0", v); end
        total++;
        if (Q !== 16'h0022) begin bad++; $display("FAIL tie_q: got %h want 0022", Q); end
        run_tie(n, e0, e1, e2, e3, v);
        total++;
        if (n !== 4 || e0 !== 0 || e1 !== 2 || e2 !== 1 || e3 !== 3) begin
            bad++; $display("FAIL tie_repeat: got n=%0d %0d %0d %0d %0d want n=4 0 2 1 3", n, e0, e1, e2, e3);
        end
    endtask

    task automatic test_reset_mid_rot();
        int g, dc, b, n, e0, e1, e2, e3, v, seen;
        logic di;
        do_reset();
        run_cmd(1'b0, 1'b0, 4'd0, 8'hF0, g, dc, di, b);
        run_cmd(1'b0, 1'b1, 4'd8, 8'h00, g, dc, di, b);
        run_cmd(1'b0, 1'b0, 4'd0, 8'h0F, g, dc, di, b);
        total++;
        if (Q !== 16'hF00F) begin bad++; $display("FAIL preset_f00f: got %h want f00f", Q); end
        req0 = 1'b1; cmd0 = 1'b1; amt0 = 4'd10;
        tick();
        req0 = 1'b0;
        total++;
        if (gnt0 !== 1'b1) begin bad++; $display("FAIL mid_gnt: got %b want 1", gnt0); end
        for (int i = 0; i < 4; i++) tick();
        total++;
        if (Q !== 16'hFF00) begin bad++; $display("FAIL mid_4shifts: got %h want ff00", Q); end
        R = 1'b0;
        #1;
        total++;
        if (Q !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL async_reset: got Q=%h busy=%b done=%b want 0000 0 0", Q, busy, done);
        end
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done !== 1'b0) seen++;
        end
        R = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done !== 1'b0) seen++;
        end
        total++;
        if (seen !== 0) begin bad++; $display("FAIL aborted_done: got %0d pulses want 0", seen); end
        run_tie(n, e0, e1, e2, e3, v);
        total++;
        if (n < 1 || e0 !== 0) begin
            bad++; $display("FAIL tie_after_reset: got first=%0d n=%0d want first=0", e0, n);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        R = 1'b0;
        req0 = 1'b0; req1 = 1'b0; cmd0 = 1'b0; cmd1 = 1'b0;
        amt0 = 4'd0; amt1 = 4'd0; d0 = 8'h00; d1 = 8'h00;
        test_reset();
        test_load();
        test_upper_byte();
        test_rotate();
        test_rot_zero();
        test_back_to_back();
        test_reset_mid_rot();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rot_arbiter.md
# rot_arbiter

Two-port arbiter and sequencer for the shared 16-bit rotate register used in the lab4 datapath. Two requesters issue byte-load or rotate-right commands. The block grants them round-robin and runs each command on an internal 16-bit register, one bit per clock. It signals completion with a tagged one-cycle pulse.

## Interface

- W, 16, register width (fixed; not for override)
- CW, 4, rotate-amount width; max amount 2^CW-1

- clk  in  1  rising-edge clock
- R  in  1  reset; asynchronous, active-low (R=0 resets)
- req0, req1  in  1  request from requester 0 / 1
- cmd0, cmd1  in  1  command: 0 = load byte, 1 = rotate right
- amt0, amt1  in  CW  rotate amount (used when cmd=1)
- d0, d1  in  8  load data (used when cmd=0)
- gnt0, gnt1  out  1  one-cycle pulse: request accepted, operands captured
- busy  out  1  high when state != IDLE
- done  out  1  one-cycle pulse: command finished
- done_id  out  1  requester served by the finishing command (valid while done=1)
- Q  out  W  register contents

## Operation

- States: IDLE, LOAD, ROT, DONE.
- IDLE: requests are sampled only in this state.
  - If any req is high at the edge, capture that requester's cmd/amt/d and set cur_id.
  - Assert the matching gnt for the next cycle only.
  - Go to LOAD (cmd=0) or ROT (cmd=1). The counter cnt is loaded with amt.
- Arbitration is round-robin on pointer last (the id last served).
  - Single request: grant it.
  - Both requesting: grant !last. Update last <= granted id.
  - Reset value last=1, so requester 0 wins the first tie.
- LOAD: Q <= {Q[15:8], d_captured}. Next state DONE.
- ROT, on each edge:
  - If cnt==0, go to DONE with Q unchanged.
  - Otherwise Q <= {Q[0], Q[15:1]} and cnt <= cnt-1.
  - Net effect: rotate right by amt (0..15). amt=0 leaves Q unchanged.
- DONE: done=1 and done_id=cur_id for this cycle. Next state IDLE.
- Requests in LOAD, ROT or DONE are ignored, not queued.
  - A requester must drop req in its gnt cycle.
  - A req still high when the block returns to IDLE is granted again as a new command.
- Operands are captured at grant. Changes to cmd/amt/d after grant have no effect.
- Reset, at any time, including mid-ROT:
  - Immediately: Q=0, state=IDLE, cnt=0, gnt0=gnt1=0, busy=0, done=0, done_id=0, last=1.
  - The aborted command produces no done pulse.

## Timing

- E0 is the edge that samples req in IDLE. gnt and busy are high from E0 to E1.
- LOAD:
  - Q updated at E1; done high E1–E2; IDLE at E2.
  - Next request sampled at E3. Load throughput is one command per 3 cycles.
- ROT with amt=k:
  - Shifts at E1..Ek; DONE entered at E(k+1); done high E(k+1)–E(k+2); IDLE at E(k+2).
  - amt=0: done high E1–E2.
- All outputs are registered. No combinational path from inputs to outputs.
- gnt0 and gnt1 are never high together.
- done is never high in the same cycle as any gnt.

## Test plan

- Reset, then Q=0. req0 with cmd0=0, d0=8'hA5:
  - gnt0 pulse after E0; Q=16'h00A5 after E1.
  - done=1 with done_id=0 one cycle after gnt0.
- Q=16'h1234, then req1 load d1=8'hFF: Q=16'h12FF. Upper byte preserved.
- Q=16'h0001:
  - req0 rotate amt0=1 gives Q=16'h8000, done 2 cycles after gnt0.
  - amt0=15 from 16'h0001 gives 16'h0002, done 16 cycles after gnt.
- req0 and req1 both high from reset, each held until its gnt:
  - Order is gnt0, then done(id 0), then gnt1, then done(id 1).
  - Repeat the tie: gnt0 is granted again (last=1 after serving requester 1).
- Rotate with amt=0: Q unchanged; done one cycle after gnt; busy high for exactly 2 cycles.
- Start rotate amt=10 on 16'hF00F. Pull R low after 4 shifts:
  - Q=0, busy=0 immediately; no done pulse.
  - After R is released, the next tie goes to requester 0.
